// File: rtl/ntt_butterfly_forward_stream.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_butterfly_forward_stream (with mod_mult, mod_add, mod_sub)
//  Description : Streaming Cooley-Tukey forward-NTT butterfly.
//                t = b*tw mod Q, a' = (a + t) mod Q, b' = (a - t) mod Q.
//                A valid/ready front end, an occupancy (credit) counter and an
//                output FIFO let the consumer stall a non-stallable multiplier.
//  Ports       : clk, rst_n (async, active low)
//                i_in_valid / o_in_ready      : input handshake
//                i_in_a, i_in_b, i_in_twiddle : operands, all < Q
//                i_in_idx                     : opaque tag, returned unchanged
//                o_out_valid / i_out_ready    : output handshake (FIFO head)
//                o_out_a, o_out_b, o_out_idx  : result at the FIFO head
//                o_busy                       : any item in pipeline or FIFO
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// mod_mult: (a*b) mod Q, or Montgomery a*b*2^-WIDTH mod Q when
// REDUCTION_TYPE = 2. Operands are registered, reduced, then pass through
// PIPELINE_STAGES more registers: PIPELINE_STAGES+1 register stages in total.
// ----------------------------------------------------------------------------
module mod_mult #(
  parameter int          WIDTH           = 32,
  parameter int unsigned Q               = 8380417,
  parameter int          REDUCTION_TYPE  = 0,
  parameter int          PIPELINE_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_red;

  // Newton iteration for -Q^-1 mod 2^WIDTH; starting from Q gives 3 correct
  // bits, each step doubles them.
  function automatic logic [WIDTH-1:0] f_neg_qinv();
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] inv;
    q   = WIDTH'(Q);
    inv = q;
    for (int i = 0; i < 6; i++) begin
      inv = inv * (WIDTH'(2) - q * inv);
    end
    return ~inv + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      r_a <= i_a;
      r_b <= i_b;
    end
  end

  assign w_prod = (2*WIDTH)'(r_a) * (2*WIDTH)'(r_b);

  generate
    if (REDUCTION_TYPE == 2) begin : g_mont
      localparam logic [WIDTH-1:0]   c_QINV_NEG = f_neg_qinv();
      localparam logic [WIDTH:0]     c_Q1       = (WIDTH+1)'(Q);
      localparam logic [2*WIDTH:0]   c_QW       = (2*WIDTH+1)'(Q);
      logic [WIDTH-1:0] w_m;
      logic [WIDTH:0]   w_u;
      // REDC: (T + m*Q) is divisible by 2^WIDTH and the quotient is < 2Q.
      assign w_m   = w_prod[WIDTH-1:0] * c_QINV_NEG;
      assign w_u   = (WIDTH+1)'(({1'b0, w_prod} + (2*WIDTH+1)'(w_m) * c_QW) >> WIDTH);
      assign w_red = (w_u >= c_Q1) ? WIDTH'(w_u - c_Q1) : WIDTH'(w_u);
    end else begin : g_plain
      localparam logic [2*WIDTH-1:0] c_Q2 = (2*WIDTH)'(Q);
      assign w_red = WIDTH'(w_prod % c_Q2);
    end
  endgenerate

  generate
    if (PIPELINE_STAGES == 0) begin : g_nopipe
      assign o_p = w_red;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_pipe [PIPELINE_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPELINE_STAGES; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_red;
          for (int i = 1; i < PIPELINE_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign o_p = r_pipe[PIPELINE_STAGES-1];
    end
  endgenerate

endmodule

// ----------------------------------------------------------------------------
// mod_add: (a + b) mod Q for a, b < Q.
// ----------------------------------------------------------------------------
module mod_add #(
  parameter int          WIDTH = 32,
  parameter int unsigned Q     = 8380417
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_s
);
  localparam logic [WIDTH:0] c_Q1 = (WIDTH+1)'(Q);
  logic [WIDTH:0] w_s;
  assign w_s = {1'b0, i_a} + {1'b0, i_b};
  assign o_s = (w_s >= c_Q1) ? WIDTH'(w_s - c_Q1) : WIDTH'(w_s);
endmodule

// ----------------------------------------------------------------------------
// mod_sub: (a - b) mod Q for a, b < Q.
// ----------------------------------------------------------------------------
module mod_sub #(
  parameter int          WIDTH = 32,
  parameter int unsigned Q     = 8380417
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_d
);
  localparam logic [WIDTH:0] c_Q1 = (WIDTH+1)'(Q);
  logic [WIDTH:0] w_d;
  assign w_d = {1'b0, i_a} - {1'b0, i_b};
  // On borrow, adding Q modulo 2^(WIDTH+1) lands back in [0, Q-1].
  assign o_d = (i_a >= i_b) ? WIDTH'(w_d) : WIDTH'(w_d + c_Q1);
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module ntt_butterfly_forward_stream #(
  parameter int          WIDTH          = 32,
  parameter int unsigned Q              = 8380417,
  parameter int          REDUCTION_TYPE = 0,
  parameter int          MULT_PIPELINE  = 3,
  parameter int          IDX_WIDTH      = 8,
  parameter int          FIFO_DEPTH     = MULT_PIPELINE + 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_in_a,
  input  logic [WIDTH-1:0]     i_in_b,
  input  logic [WIDTH-1:0]     i_in_twiddle,
  input  logic [IDX_WIDTH-1:0] i_in_idx,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WIDTH-1:0]     o_out_a,
  output logic [WIDTH-1:0]     o_out_b,
  output logic [IDX_WIDTH-1:0] o_out_idx,
  output logic                 o_busy
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OCC_W-1:0] c_DEPTH    = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam int P = MULT_PIPELINE;

  logic w_accept;
  logic w_pop;
  logic w_push;

  // Alignment shift register: stage P lines up with the multiplier output.
  logic                 r_vld_sr [0:P];
  logic [WIDTH-1:0]     r_a_sr   [0:P];
  logic [IDX_WIDTH-1:0] r_idx_sr [0:P];

  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;

  // Result stage
  logic                 r_res_vld;
  logic [WIDTH-1:0]     r_res_a;
  logic [WIDTH-1:0]     r_res_b;
  logic [IDX_WIDTH-1:0] r_res_idx;

  // Output FIFO
  logic [WIDTH-1:0]     r_mem_a   [FIFO_DEPTH];
  logic [WIDTH-1:0]     r_mem_b   [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0] r_mem_idx [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [OCC_W-1:0]     r_cnt;

  // Last popped head, shown while the FIFO is empty so outputs hold.
  logic [WIDTH-1:0]     r_hold_a;
  logic [WIDTH-1:0]     r_hold_b;
  logic [IDX_WIDTH-1:0] r_hold_idx;

  logic [OCC_W-1:0] r_occ;

  // Credit rule: ready depends only on the registered occupancy, so every
  // accepted item already owns a FIFO slot when it reaches the result stage.
  assign o_in_ready  = (r_occ < c_DEPTH);
  assign o_busy      = (r_occ != '0);
  assign o_out_valid = (r_cnt != '0);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_push      = r_res_vld;

  mod_mult #(
    .WIDTH           (WIDTH),
    .Q               (Q),
    .REDUCTION_TYPE  (REDUCTION_TYPE),
    .PIPELINE_STAGES (MULT_PIPELINE)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_a   (i_in_b),
    .i_b   (i_in_twiddle),
    .o_p   (w_t)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= P; i++) begin
        r_vld_sr[i] <= 1'b0;
        r_a_sr[i]   <= '0;
        r_idx_sr[i] <= '0;
      end
    end else begin
      r_vld_sr[0] <= w_accept;
      r_a_sr[0]   <= i_in_a;
      r_idx_sr[0] <= i_in_idx;
      for (int i = 1; i <= P; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
        r_a_sr[i]   <= r_a_sr[i-1];
        r_idx_sr[i] <= r_idx_sr[i-1];
      end
    end
  end

  mod_add #(.WIDTH(WIDTH), .Q(Q)) u_add (
    .i_a (r_a_sr[P]),
    .i_b (w_t),
    .o_s (w_sum)
  );

  mod_sub #(.WIDTH(WIDTH), .Q(Q)) u_sub (
    .i_a (r_a_sr[P]),
    .i_b (w_t),
    .o_d (w_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_vld <= 1'b0;
      r_res_a   <= '0;
      r_res_b   <= '0;
      r_res_idx <= '0;
    end else begin
      r_res_vld <= r_vld_sr[P];
      if (r_vld_sr[P]) begin
        r_res_a   <= w_sum;
        r_res_b   <= w_diff;
        r_res_idx <= r_idx_sr[P];
      end
    end
  end

  // FIFO storage carries no reset; only pointers and count define content.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= r_res_a;
      r_mem_b[r_wr_ptr]   <= r_res_b;
      r_mem_idx[r_wr_ptr] <= r_res_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_hold_a   <= '0;
      r_hold_b   <= '0;
      r_hold_idx <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr   <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
        r_hold_a   <= r_mem_a[r_rd_ptr];
        r_hold_b   <= r_mem_b[r_rd_ptr];
        r_hold_idx <= r_mem_idx[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // A push into a full FIFO would mean the credit accounting is broken.
  a_fifo_no_overflow : assert property (
    @(posedge clk) disable iff (!rst_n) !(w_push && (r_cnt == c_DEPTH))
  );

  // Pushed items are never bypassed: an empty FIFO shows the held value.
  assign o_out_a   = o_out_valid ? r_mem_a[r_rd_ptr]   : r_hold_a;
  assign o_out_b   = o_out_valid ? r_mem_b[r_rd_ptr]   : r_hold_b;
  assign o_out_idx = o_out_valid ? r_mem_idx[r_rd_ptr] : r_hold_idx;

endmodule

`default_nettype wire

// File: tb/tb_ntt_butterfly_forward_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_butterfly_forward_stream
//  Description : Directed-vector bench for the forward NTT butterfly. A plain
//                reduction instance and a Montgomery instance run in lockstep
//                on the same plain-domain data; both are scored against the
//                same expected queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_butterfly_forward_stream;

  localparam int          W  = 32;
  localparam int unsigned Q  = 8380417;
  localparam int          P  = 3;
  localparam int          D  = P + 4;
  localparam int          IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [W-1:0]  in_tw = '0;
  logic [W-1:0]  in_tw_m = '0;
  logic [IW-1:0] in_idx = '0;

  logic          in_ready, out_valid, busy;
  logic [W-1:0]  out_a, out_b;
  logic [IW-1:0] out_idx;
  logic          m_in_ready, m_out_valid, m_busy;
  logic [W-1:0]  m_out_a, m_out_b;
  logic [IW-1:0] m_out_idx;

  always #5 clk = ~clk;

  ntt_butterfly_forward_stream #(
    .WIDTH(W), .Q(Q), .REDUCTION_TYPE(0), .MULT_PIPELINE(P), .IDX_WIDTH(IW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_twiddle(in_tw), .i_in_idx(in_idx),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_a(out_a), .o_out_b(out_b), .o_out_idx(out_idx), .o_busy(busy)
  );

  ntt_butterfly_forward_stream #(
    .WIDTH(W), .Q(Q), .REDUCTION_TYPE(2), .MULT_PIPELINE(P), .IDX_WIDTH(IW), .FIFO_DEPTH(D)
  ) dut_m (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(m_in_ready),
    .i_in_a(in_a), .i_in_b(in_b), .i_in_twiddle(in_tw_m), .i_in_idx(in_idx),
    .o_out_valid(m_out_valid), .i_out_ready(out_ready),
    .o_out_a(m_out_a), .o_out_b(m_out_b), .o_out_idx(m_out_idx), .o_busy(m_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  q_a [$];
  logic [W-1:0]  q_b [$];
  logic [IW-1:0] q_idx [$];
  logic [W-1:0]  cur_ea, cur_eb;
  int            tag_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_mont(input logic [W-1:0] x);
    logic [63:0] t;
    t = {x, 32'b0};
    return W'(t % 64'(Q));
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] tw,
                       input logic [IW-1:0] idx, input logic [W-1:0] ea, input logic [W-1:0] eb);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tw    = tw;
    in_tw_m  = to_mont(tw);
    in_idx   = idx;
    cur_ea   = ea;
    cur_eb   = eb;
  endtask

  task automatic drive_rand();
    logic [63:0] a, b, tw, t;
    a  = 64'($urandom_range(0, Q - 1));
    b  = 64'($urandom_range(0, Q - 1));
    tw = 64'($urandom_range(0, Q - 1));
    t  = (b * tw) % 64'(Q);
    drive(W'(a), W'(b), W'(tw), IW'(tag_cnt),
          W'((a + t) % 64'(Q)), W'((a + 64'(Q) - t) % 64'(Q)));
    tag_cnt++;
  endtask

  // Evaluate handshakes for the coming edge, advance one cycle, settle.
  task automatic tick();
    logic [W-1:0]  ea, eb;
    logic [IW-1:0] ei;
    if (in_valid && in_ready) begin
      q_a.push_back(cur_ea);
      q_b.push_back(cur_eb);
      q_idx.push_back(in_idx);
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty_at_pop", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ei = q_idx.pop_front();
        chk("out_a", 64'(out_a), 64'(ea));
        chk("out_b", 64'(out_b), 64'(eb));
        chk("out_idx", 64'(out_idx), 64'(ei));
        chk("mont_out_valid", 64'(m_out_valid), 64'd1);
        chk("mont_out_a", 64'(m_out_a), 64'(ea));
        chk("mont_out_b", 64'(m_out_b), 64'(eb));
        chk("mont_out_idx", 64'(m_out_idx), 64'(ei));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (busy || out_valid); i++) tick();
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_sb_empty", 64'(q_a.size()), 64'd0);
  endtask

  initial begin
    int lat;
    int drops;
    int acc;
    int seen;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_out_a", 64'(out_a), 64'd0);
    chk("reset_out_b", 64'(out_b), 64'd0);
    chk("reset_out_idx", 64'(out_idx), 64'd0);

    // Basic vector and latency: t = 6, 5+6 = 11, 5-6 = Q-1.
    out_ready = 1'b0;
    drive(5, 3, 2, 8'h11, 11, 8380416);
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int j = 1; j <= 12 && lat < 0; j++) begin
      tick();
      if (out_valid) lat = j;
    end
    chk("latency", 64'(lat), 64'(P + 2));
    chk("basic_a", 64'(out_a), 64'd11);
    chk("basic_b", 64'(out_b), 64'd8380416);
    chk("basic_idx", 64'(out_idx), 64'h11);
    tick();
    tick();
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_a", 64'(out_a), 64'd11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_pop_valid", 64'(out_valid), 64'd0);
    chk("after_pop_busy", 64'(busy), 64'd0);
    chk("after_pop_hold_a", 64'(out_a), 64'd11);
    chk("after_pop_hold_idx", 64'(out_idx), 64'h11);

    // Wrap-around vectors: t = Q-1 and t = (Q-1)^2 mod Q = 1.
    out_ready = 1'b1;
    drive(0, 1, 8380416, 8'h21, 8380416, 1);
    tick();
    drive(8380416, 8380416, 8380416, 8'h22, 0, 8380415);
    tick();
    drain();

    // Streaming: 256 back-to-back random triples.
    drops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive_rand();
      if (!in_ready) drops++;
      tick();
    end
    chk("stream_ready_drops", 64'(drops), 64'd0);
    drain();

    // Backpressure fill: exactly D accepts with out_ready held low.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 15; i++) begin
      drive_rand();
      if (in_ready) acc++;
      tick();
    end
    chk("fill_accepts", 64'(acc), 64'(D));
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // Random backpressure and input gaps.
    for (int i = 0; i < 300; i++) begin
      drive_rand();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Reset with 3 items buffered and 4 in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_in_ready", 64'(in_ready), 64'd1);
    chk("mid_reset_out_a", 64'(out_a), 64'd0);
    q_a.delete();
    q_b.delete();
    q_idx.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || m_out_valid) seen++;
      tick();
    end
    chk("post_reset_no_output", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
